regfile_mp_sb: RTL

Parametrised multi-read-port register file with a per-register busy scoreboard for the modified MIPS datapath. Replaces the fixed 32x32 three-read file in decode: one write port at writeback, NUM_RD registered read ports, and a pending-write scoreboard so decode can detect RAW hazards on in-flight destinations. Register 0 is hardwired to zero and never busy.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/regfile_mp_sb.sv | 98 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
// Latency: none (compile-time definitions only).
// Backpressure: none; optional build macro REGFILE_BYPASS_EN is consumed by regfile_mp_sb.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 3;
    localparam int MAX_NUM_RD = 8;

    // Architectural zero register: reads as 0, never written, never busy.
    localparam int REG_ZERO = 0;

    // LSB of lane 'port' in a bus that packs equal-width lanes side by side.
    function automatic int sliceLsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard with a registered busy-register count.
// Latency: busy set/clear lands at the edge; busyNext exposes the post-edge view combinationally.
// Backpressure: none; reserve beats clear on the same register, r0 never goes busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wrEn,
    input  logic [ADDR_W-1:0]      wrAddr,
    input  logic                   rsvEn,
    input  logic [ADDR_W-1:0]      rsvAddr,
    output logic [2**ADDR_W-1:0]   busyVec,
    output logic [2**ADDR_W-1:0]   busyNext,
    output logic [ADDR_W:0]        busyCnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [ADDR_W:0] cntNext;

    // Clear first, then set, so a new producer reserved on the writeback edge stays pending.
    always_comb begin
        busyNext = busyVec;
        if (wrEn && (wrAddr != ADDR_W'(REG_ZERO))) begin
            busyNext[wrAddr] = 1'b0;
        end
        if (rsvEn && (rsvAddr != ADDR_W'(REG_ZERO))) begin
            busyNext[rsvAddr] = 1'b1;
        end
        busyNext[REG_ZERO] = 1'b0;
    end

    always_comb begin
        cntNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cntNext = cntNext + (ADDR_W+1)'(busyNext[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyVec <= '0;
            busyCnt <= '0;
        end else begin
            busyVec <= busyNext;
            busyCnt <= cntNext;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Register file: one writeback port, NUM_RD registered read ports, RAW busy scoreboard.
// Latency: 1 cycle read; REGFILE_BYPASS_EN selects write-first forwarding, else read-first.
// Backpressure: none; a port with rd_en low holds its last data and busy flag.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busyVec;
    logic              wrHit;

    logic [ADDR_W-1:0] portAddr [NUM_RD];
    logic [DATA_W-1:0] portData [NUM_RD];
    logic [NUM_RD-1:0] portBusy;

    assign wrHit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
    logic [DEPTH-1:0] busyNext;
`endif

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W)
    ) uScoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrEn     (wr_en),
        .wrAddr   (wr_addr),
        .rsvEn    (rsv_en),
        .rsvAddr  (rsv_addr),
        .busyVec  (busyVec),
`ifdef REGFILE_BYPASS_EN
        .busyNext (busyNext),
`else
        .busyNext (),
`endif
        .busyCnt  (busy_cnt)
    );

    // Entry 0 is never written, so after reset it reads 0 without an address compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrHit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            portAddr[i] = rd_addr[sliceLsb(i, ADDR_W) +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; wrHit already excludes r0.
            portData[i] = (wrHit && (wr_addr == portAddr[i])) ? wr_data : mem[portAddr[i]];
            portBusy[i] = busyNext[portAddr[i]];
`else
            portData[i] = mem[portAddr[i]];
            portBusy[i] = busyVec[portAddr[i]];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    rd_data[sliceLsb(i, DATA_W) +: DATA_W] <= portData[i];
                    rd_busy[i]                             <= portBusy[i];
                end
            end
        end
    end

endmodule
